// File: rtl/dice_pkg.sv
// Shared definitions for the dice pool roller: FSM states, LFSR constants
// and the helpers that step the LFSR and build the rejection-sampling mask.
package dice_pkg;

    localparam int          LFSR_W        = 16;
    localparam logic [15:0] LFSR_POLY     = 16'hB400;
    localparam logic [15:0] LFSR_FALLBACK = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Smallest 2^k-1 covering sides-1: every bit below the MSB of sides-1 is set.
    function automatic logic [15:0] side_mask(input logic [15:0] sides);
        logic [15:0] v;
        v = sides - 16'd1;
        v = v | (v >> 1);
        v = v | (v >> 2);
        v = v | (v >> 4);
        v = v | (v >> 8);
        return v;
    endfunction

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] v;
        v = s >> 1;
        if (s[0]) begin
            v = v ^ LFSR_POLY;
        end else begin
            v = v;
        end
        return v;
    endfunction

endpackage

// File: rtl/dice_lfsr.sv
// Free-running 16-bit Galois LFSR used as the dice entropy source.
// With DICE_POOL_SEED_LOAD_EN defined, a load strobe replaces the next state
// with a supplied seed (a zero seed falls back to the non-zero default).
module dice_lfsr
    import dice_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef DICE_POOL_SEED_LOAD_EN
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
`endif
    output logic [LFSR_W-1:0] state
);

    // An all-zero LFSR would lock up, so a zero seed is swapped for the fallback.
    localparam logic [15:0] RESET_SEED = (SEED == 16'h0000) ? LFSR_FALLBACK : SEED;

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    // Next state: seed load (when built in) overrides the normal advance.
    always_comb begin
`ifdef DICE_POOL_SEED_LOAD_EN
        if (load) begin
            state_d = (seed == 16'h0000) ? LFSR_FALLBACK : seed;
        end else begin
            state_d = lfsr_step(state_q);
        end
`else
        state_d = lfsr_step(state_q);
`endif
    end

    // LFSR register, advancing on every cycle outside reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/dice_pool_roller.sv
// Dice pool roller: rolls num_dice dice with a run-time side count, emits each
// face and the pool total. Faces come from rejection sampling on the low LFSR
// bits so every face is equally likely.
// Optional build macro DICE_POOL_SEED_LOAD_EN adds seed_load/seed inputs.
module dice_pool_roller
    import dice_pkg::*;
#(
    parameter int          MAX_SIDES = 20,
    parameter int          MAX_DICE  = 8,
    parameter logic [15:0] SEED      = 16'hACE1,
    localparam int         SIDE_W    = $clog2(MAX_SIDES + 1),
    localparam int         CNT_W     = $clog2(MAX_DICE + 1),
    localparam int         SUM_W     = $clog2(MAX_DICE * MAX_SIDES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIDE_W-1:0] sides,
    input  logic [CNT_W-1:0]  num_dice,
`ifdef DICE_POOL_SEED_LOAD_EN
    input  logic              seed_load,
    input  logic [15:0]       seed,
`endif
    output logic              busy,
    output logic              face_valid,
    output logic [SIDE_W-1:0] face,
    output logic              done,
    output logic              error,
    output logic [SUM_W-1:0]  result
);

    state_e            state_q,  state_d;
    logic [SIDE_W-1:0] sides_q,  sides_d;
    logic [CNT_W-1:0]  rem_q,    rem_d;
    logic [SUM_W-1:0]  acc_q,    acc_d;
    logic [SUM_W-1:0]  result_q, result_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              error_q,  error_d;

    logic [15:0]       lfsr_s;
    logic [15:0]       mask_full_s;
    logic [SIDE_W-1:0] cand_s;
    logic [SIDE_W-1:0] face_s;
    logic              hit_s;
    logic              illegal_s;

    dice_lfsr #(
        .SEED  (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
`ifdef DICE_POOL_SEED_LOAD_EN
        .load  (seed_load),
        .seed  (seed),
`endif
        .state (lfsr_s)
    );

    // Candidate draw from the current LFSR value, masked to the side range.
    always_comb begin
        mask_full_s = side_mask(16'(sides_q));
        cand_s      = SIDE_W'(lfsr_s & mask_full_s);
        face_s      = cand_s + SIDE_W'(1'b1);
        hit_s       = (state_q == ST_DRAW) && (cand_s < sides_q);
        illegal_s   = (sides < SIDE_W'(32'd2))
                   || (sides > SIDE_W'(MAX_SIDES))
                   || (num_dice == CNT_W'(1'b0))
                   || (num_dice > CNT_W'(MAX_DICE));
    end

    // Controller next state: accept, draw until the pool is complete, report.
    always_comb begin
        state_d  = state_q;
        sides_d  = sides_q;
        rem_d    = rem_q;
        acc_d    = acc_q;
        result_d = result_q;
        busy_d   = busy_q;
        error_d  = error_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sides_d  = sides;
                    rem_d    = num_dice;
                    acc_d    = {SUM_W{1'b0}};
                    result_d = {SUM_W{1'b0}};
                    error_d  = 1'b0;
                    busy_d   = 1'b1;
                    if (illegal_s) begin
                        state_d = ST_FIN;
                        error_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DRAW;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAW: begin
                if (hit_s) begin
                    acc_d = acc_q + SUM_W'(face_s);
                    rem_d = rem_q - CNT_W'(1'b1);
                    if (rem_q == CNT_W'(1'b1)) begin
                        state_d  = ST_FIN;
                        done_d   = 1'b1;
                        result_d = acc_q + SUM_W'(face_s);
                    end else begin
                        state_d = ST_DRAW;
                    end
                end else begin
                    state_d = ST_DRAW;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Controller and output registers; reset discards any partial roll.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sides_q  <= {SIDE_W{1'b0}};
            rem_q    <= {CNT_W{1'b0}};
            acc_q    <= {SUM_W{1'b0}};
            result_q <= {SUM_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sides_q  <= sides_d;
            rem_q    <= rem_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    // Faces are decoded from registered state so each one appears in its draw
    // cycle, keeping the last face and done in consecutive cycles.
    assign face_valid = hit_s;
    assign face       = hit_s ? face_s : {SIDE_W{1'b0}};
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign result     = result_q;

endmodule

// File: tb/tb_dice_pool_roller.sv
// Scoreboard bench for dice_pool_roller (default parameters). Stimulus pushes
// the expected faces and the expected completion record; a negedge monitor
// pops and compares whenever face_valid or done is presented.
module tb_dice_pool_roller;

    localparam int SW = 5;
    localparam int CW = 4;
    localparam int UW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [SW-1:0] sides = '0;
    logic [CW-1:0] num_dice = '0;
`ifdef DICE_POOL_SEED_LOAD_EN
    logic          seed_load = 1'b0;
    logic [15:0]   seed = 16'h0000;
`endif
    logic          busy, face_valid, done, error;
    logic [SW-1:0] face;
    logic [UW-1:0] result;

    dice_pool_roller dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sides      (sides),
        .num_dice   (num_dice),
`ifdef DICE_POOL_SEED_LOAD_EN
        .seed_load  (seed_load),
        .seed       (seed),
`endif
        .busy       (busy),
        .face_valid (face_valid),
        .face       (face),
        .done       (done),
        .error      (error),
        .result     (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int err;
        int lat;
    } exp_t;

    exp_t        dq[$];
    int          fq[$];
    int          cap[$];
    int          cap_a[$];
    int          hist[21];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          ignore = 1'b0;
    bit          hist_en = 1'b0;
    bit          cap_en = 1'b0;
    int          k = 0;
    bit          prev_busy = 1'b0;
    int          last_result = 0;
    logic [15:0] m;

    function automatic logic [15:0] step(input logic [15:0] s);
        logic [15:0] v;
        v = {1'b0, s[15:1]};
        if (s[0]) v = v ^ 16'hB400;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference LFSR, reset and stepped like the spec describes.
    always @(posedge clk or posedge rst) begin
        if (rst) m <= 16'hACE1;
`ifdef DICE_POOL_SEED_LOAD_EN
        else if (seed_load) m <= (seed == 16'h0000) ? 16'hACE1 : seed;
`endif
        else m <= step(m);
    end

    // Monitor: compare faces and completions against the scoreboard queues.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            k = 0;
            prev_busy = 1'b0;
            last_result = 0;
        end else if (!ignore) begin
            if (busy && !prev_busy) k = 1;
            else if (busy) k++;
            prev_busy = busy;
            if (face_valid) begin
                if (fq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_face: got face %0d, required none", face);
                end else begin
                    chk("face", face, fq.pop_front());
                end
                if (hist_en && face <= 20) hist[face]++;
                if (cap_en) cap.push_back(int'(face));
            end
            if (done) begin
                if (dq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done with result %0d, required none", result);
                end else begin
                    e = dq.pop_front();
                    chk("result", result, e.sum);
                    chk("error", error, e.err);
                    chk("latency", k, e.lat);
                    chk("busy_at_done", busy, 1);
                    chk("result_max", result <= 160, 1);
                end
                last_result = int'(result);
            end else if (!busy) begin
                chk("result_hold", result, last_result);
            end
        end else begin
            prev_busy = busy;
        end
    end

    // Issue one request from a negedge with the DUT idle; returns once idle again.
    task automatic roll(input int s, input int n, input int extra);
        exp_t        e;
        int          msk, got, draws, cand, sum, cnt;
        logic [15:0] l;
        if (s >= 2 && s <= 20 && n >= 1 && n <= 8) begin
            msk = 0;
            while (msk < s - 1) msk = msk * 2 + 1;
            l = step(m);
            got = 0; draws = 0; sum = 0;
            while (got < n) begin
                cand = int'(l[4:0]) & msk;
                if (cand < s) begin
                    fq.push_back(cand + 1);
                    sum += cand + 1;
                    got++;
                end
                draws++;
                l = step(l);
            end
            e.sum = sum;
            e.err = 0;
            e.lat = ((s & (s - 1)) == 0) ? n + 1 : draws + 1;
        end else begin
            e.sum = 0;
            e.err = 1;
            e.lat = 1;
        end
        dq.push_back(e);
        start = 1'b1;
        sides = s[SW-1:0];
        num_dice = n[CW-1:0];
        @(negedge clk);
        start = 1'b0;
        sides = 5'd1;
        num_dice = 4'd0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 300) begin
            @(negedge clk);
            cnt++;
            if (extra > 0 && cnt == extra) begin
                start = 1'b1;
                sides = 5'd6;
                num_dice = 4'd2;
            end else if (extra > 0 && cnt == extra + 1) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (cnt >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL roll_timeout: got busy after %0d cycles, required idle", cnt);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_face_valid"}, face_valid, 0);
        chk({tag, "_face"}, face, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_result"}, result, 0);
    endtask

    initial begin
        for (int i = 0; i < 21; i++) hist[i] = 0;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        rst = 1'b0;
        @(negedge clk);

        roll(6, 3, 0);
        roll(6, 3, 0);
        roll(8, 4, 0);
        roll(2, 1, 0);
        roll(20, 8, 0);
        roll(1, 3, 0);
        roll(6, 0, 0);
        roll(21, 2, 0);
        roll(6, 9, 0);
        roll(20, 8, 2);
        repeat (4) @(negedge clk);

        // Reset in the middle of a draw sequence.
        ignore = 1'b1;
        start = 1'b1;
        sides = 5'd20;
        num_dice = 4'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        chk("midrst_busy_next", busy, 0);
        chk("midrst_done_next", done, 0);
        rst = 1'b0;
        ignore = 1'b0;
        repeat (3) @(negedge clk);
        roll(6, 3, 0);

        hist_en = 1'b1;
        for (int i = 0; i < 2000; i++) roll(20, 8, 0);
        hist_en = 1'b0;
        for (int f = 1; f <= 20; f++) begin
            n_cmp++;
            if (hist[f] < 640 || hist[f] > 960) begin
                n_bad++;
                $display("FAIL hist_face%0d: got %0d hits, required 640..960", f, hist[f]);
            end
        end

`ifdef DICE_POOL_SEED_LOAD_EN
        for (int pass = 0; pass < 4; pass++) begin
            seed_load = 1'b1;
            seed = (pass < 2) ? 16'h1234 : ((pass == 2) ? 16'h0000 : 16'hACE1);
            @(negedge clk);
            seed_load = 1'b0;
            cap.delete();
            cap_en = 1'b1;
            roll(20, 8, 0);
            cap_en = 1'b0;
            if (pass == 0 || pass == 2) begin
                cap_a = cap;
            end else begin
                chk("seed_cap_len", cap.size(), cap_a.size());
                for (int i = 0; i < cap.size() && i < cap_a.size(); i++)
                    chk("seed_repeat_face", cap[i], cap_a[i]);
            end
        end
`endif

        repeat (3) @(negedge clk);
        chk("done_queue_empty", dq.size(), 0);
        chk("face_queue_empty", fq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, required $finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
